// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, named register indices and regfile FSM states
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA = 5'd31;
  typedef enum logic {CLEAR, RUN} regfile_state_t;
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: post-reset sequencer zeroing entries 1..top one per cycle
module regfile_clear_seq
  import mips_pkg::*;
#(
  parameter int ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_wa
);
  regfile_state_t state, state_next;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= ADDR_W'(1);
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end
  // pointer wraps to 0 naturally after writing the top entry
  always_comb begin
    state_next   = (state == CLEAR && clr_ptr == '1) ? RUN : state;
    clr_ptr_next = (state == CLEAR) ? clr_ptr + ADDR_W'(1) : clr_ptr;
  end
  always_comb begin
    busy   = (state == CLEAR);
    clr_we = (state == CLEAR);
    clr_wa = clr_ptr;
  end
endmodule

// File: rtl/mips_regfile.sv
// mips_regfile: 32-entry 2R/1W register file with post-reset clear sequencer;
// define REGFILE_BYPASS_EN for write-first forwarding on the read ports
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic              busy
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_wa;
  logic              user_we;
  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk   (clk),
    .rst   (rst),
    .busy  (busy),
    .clr_we(clr_we),
    .clr_wa(clr_wa)
  );
  assign user_we = we && !busy && wa != '0;
  // storage has no reset so it can map to distributed RAM
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_wa] <= '0;
    else if (user_we) mem[wa] <= wd;
  end
`ifdef REGFILE_BYPASS_EN
  assign rd1 = (busy || ra1 == '0) ? '0 : (we && ra1 == wa) ? wd : mem[ra1];
  assign rd2 = (busy || ra2 == '0) ? '0 : (we && ra2 == wa) ? wd : mem[ra2];
`else
  assign rd1 = (busy || ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (busy || ra2 == '0) ? '0 : mem[ra2];
`endif
endmodule

// File: tb/tb_mips_regfile.sv
// tb_mips_regfile: directed + randomized checks against a behavioural register-file model
module tb_mips_regfile;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, we = 1'b0, busy;
  logic [4:0] ra1 = '0, ra2 = '0, wa = '0;
  logic [31:0] wd = '0, rd1, rd2;
  logic [31:0] ref_mem [32];
  int clear_left = 0, checks = 0, errors = 0, n;
  bit armed = 1'b0;
  mips_regfile dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (clear_left > 0 || ra == 0) return '0;
    if (BYP && we && wa == ra) return wd;
    return ref_mem[ra];
  endfunction
  task automatic tick();
    @(negedge clk);
    if (armed) begin
      check("busy", {31'b0, busy}, {31'b0, clear_left > 0});
      check("rd1", rd1, exp_rd(ra1));
      check("rd2", rd2, exp_rd(ra2));
    end
    @(posedge clk);
    if (rst) begin
      clear_left = 31;
      foreach (ref_mem[i]) ref_mem[i] = '0;
      armed = 1'b1;
    end else if (clear_left > 0) clear_left--;
    else if (we && wa != 0) ref_mem[wa] = wd;
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask
  task automatic count_busy();
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("busy_len", n, 31);
  endtask
  initial begin
    rst = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    count_busy();
    we = 1'b0; ra1 = 5'd5; #1;
    check("dropped_wr", rd1, 32'h0);
    wr(5'd3, 32'h12);
    ra1 = 5'd3; ra2 = 5'd3; #1;
    check("r3_p1", rd1, 32'h12);
    check("r3_p2", rd2, 32'h12);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; #1;
    check("r0_same", rd1, 32'h0);
    tick();
    we = 1'b0; #1;
    check("r0_after", rd1, 32'h0);
    wr(5'd7, 32'h1);
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5; ra2 = 5'd7; #1;
    check("rdw_same", rd2, BYP ? 32'hA5A5 : 32'h1);
    tick();
    we = 1'b0; #1;
    check("rdw_next", rd2, 32'hA5A5);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (9) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    count_busy();
    ra1 = 5'd3; #1;
    check("r3_cleared", rd1, 32'h0);
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(32 - i); #1;
      check("pair_rd1", rd1, 32'(i));
      check("pair_rd2", rd2, 32'(32 - i));
      tick();
    end
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      we = $urandom_range(0, 1) == 1;
      wa = 5'($urandom); wd = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      tick();
    end
    rst = 1'b0; we = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
